gzip_sched: RTL and testbench

Round-robin scheduler that shares one lz77/huffman compression engine between `NREQ` requesters. Each requester submits a 120-bit block (15 bytes, MSB-first, zero-padded on the left). The scheduler grants one requester at a time and launches the engine with a start pulse. It waits for the engine's done indication and captures the 32-token result. It then streams the tokens back tagged with the requester ID, stopping at the end-of-string token. It sits between the host-side block producers and the `gzip` datapath.

---
 rtl/gzip_sched.sv | 125 ++++++++++++
 tb/tb_gzip_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gzip_sched.sv
// Round-robin scheduler sharing one lz77/huffman engine between NREQ block producers.
// Grants one requester, launches the engine, captures its tokens and streams them back tagged.
module gzip_sched #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned NTOK   = 32,
  parameter int unsigned TOKW   = 11,
  parameter int unsigned MAXCYC = 64,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*120-1:0]  req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 eng_start,
  output logic [119:0]         eng_x,
  input  logic                 eng_done,
  input  logic [NTOK*TOKW-1:0] eng_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TOKW-1:0]      out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int unsigned TW = (NTOK > 1) ? $clog2(NTOK) : 1;
  localparam int unsigned CW = $clog2(MAXCYC + 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDrain} state_e;

  state_e                     state_q;
  logic [IDW-1:0]             rr_q;
  logic [TW-1:0]              tok_q;
  logic [CW-1:0]              cnt_q;
  logic [NTOK-1:0][TOKW-1:0]  buf_q;

  logic [2*NREQ-1:0]          rot;
  logic                       grant_any;
  logic [IDW-1:0]             grant_id;
  logic [TOKW-1:0]            cur_tok;
  logic                       cur_last;

  // Rotate the request vector so bit 0 is the requester at the round-robin pointer.
  always_comb begin : arbiter
    int s;
    rot       = {req_valid, req_valid} >> rr_q;
    grant_any = 1'b0;
    grant_id  = '0;
    s         = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!grant_any && rot[i]) begin
        grant_any = 1'b1;
        s = int'(rr_q) + i;
        if (s >= int'(NREQ)) s = s - int'(NREQ);
        grant_id = IDW'(s);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_any) req_ready[grant_id] = 1'b1;
  end

  assign cur_tok   = buf_q[tok_q];
  assign cur_last  = (cur_tok[4:0] == 5'h1f) || (tok_q == TW'(NTOK - 1));
  assign out_valid = (state_q == StDrain);
  assign out_data  = out_valid ? cur_tok : '0;
  assign out_last  = out_valid && cur_last;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      tok_q       <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      eng_start   <= 1'b0;
      eng_x       <= '0;
      out_id      <= '0;
      err_timeout <= 1'b0;
    end else begin
      eng_start   <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            eng_x     <= req_data[120*grant_id +: 120];
            out_id    <= grant_id;
            rr_q      <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            eng_start <= 1'b1;
            state_q   <= StStart;
          end
        end
        StStart: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          // A result arriving on the timeout cycle still counts as a completion.
          if (eng_done) begin
            buf_q   <= eng_y;
            tok_q   <= '0;
            state_q <= StDrain;
          end else if (cnt_q == CW'(MAXCYC - 1)) begin
            err_timeout <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (cur_last) state_q <= StIdle;
            else          tok_q   <= tok_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gzip_sched.sv
// Directed bench for gzip_sched: single grant, round-robin order, backpressure,
// engine timeout and reset during drain.
module tb_gzip_sched;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned NTOK   = 32;
  localparam int unsigned TOKW   = 11;
  localparam int unsigned MAXCYC = 64;
  localparam int unsigned IDW    = $clog2(NREQ);

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*120-1:0]  req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 eng_start;
  logic [119:0]         eng_x;
  logic                 eng_done;
  logic [NTOK*TOKW-1:0] eng_y;
  logic                 out_valid;
  logic                 out_ready;
  logic [TOKW-1:0]      out_data;
  logic [IDW-1:0]       out_id;
  logic                 out_last;
  logic                 busy;
  logic                 err_timeout;

  gzip_sched #(
    .NREQ  (NREQ),
    .NTOK  (NTOK),
    .TOKW  (TOKW),
    .MAXCYC(MAXCYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_done   (eng_done),
    .eng_y      (eng_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_last   (out_last),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_tmo   = 0;
  int n_ov    = 0;
  logic [TOKW-1:0] tok_mem [NTOK];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (eng_start)   n_start++;
    if (err_timeout) n_tmo++;
    if (out_valid)   n_ov++;
  endtask

  task automatic fill_tokens(input int nul_at, input int salt);
    for (int j = 0; j < int'(NTOK); j++) begin
      tok_mem[j] = {3'((j + salt) % 8), 3'((j * 3 + salt) % 8), 5'((j + salt) % 30)};
      if (j == nul_at) tok_mem[j][4:0] = 5'h1f;
      eng_y[TOKW*j +: TOKW] = tok_mem[j];
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req_ready"}, req_ready, 0);
    check_eq({tag, "_eng_start"}, eng_start, 0);
    check_eq({tag, "_eng_x"}, eng_x, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
    check_eq({tag, "_out_id"}, out_id, 0);
    check_eq({tag, "_out_last"}, out_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  // Consume tokens while out_valid; every cycle the presented token must be the next expected one.
  task automatic drain(input bit bp, input int exp_id, input int exp_n);
    int n;
    int ph;
    n  = 0;
    ph = 0;
    for (int c = 0; c < 200 && out_valid; c++) begin
      out_ready = bp ? (ph % 3 == 0) : 1'b1;
      ph++;
      check_eq("drain_data", out_data, tok_mem[n % NTOK]);
      check_eq("drain_id", out_id, exp_id);
      check_eq("drain_last", out_last, (n == exp_n - 1));
      if (out_ready) n++;
      tick();
    end
    out_ready = 1'b1;
    check_eq("drain_count", n, exp_n);
  endtask

  task automatic run_block(input int exp_g, input int lat, input int nul_at, input bit bp,
                           input bit drop, input int salt);
    int s0;
    fill_tokens(nul_at, salt);
    #1;
    check_eq("grant", req_ready, 128'(1) << exp_g);
    s0 = n_start;
    tick();
    if (drop) req_valid = '0;
    check_eq("eng_start", eng_start, 1);
    check_eq("eng_x", eng_x, req_data[120*exp_g +: 120]);
    check_eq("start_id", out_id, exp_g);
    check_eq("busy_start", busy, 1);
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c == lat) eng_done = 1'b1;
    end
    tick();
    eng_done = 1'b0;
    check_eq("first_valid", out_valid, 1);
    drain(bp, exp_g, (nul_at < 0) ? int'(NTOK) : nul_at + 1);
    check_eq("one_start", n_start - s0, 1);
    check_eq("idle_busy", busy, 0);
  endtask

  initial begin
    int t0;
    int o0;
    reset     = 1'b1;
    req_valid = '0;
    eng_done  = 1'b0;
    eng_y     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < int'(NREQ); i++)
      for (int j = 0; j < 15; j++) req_data[120*i + 8*j +: 8] = 8'(16 * i + j + 1);

    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;

    // Single request from requester 2, NUL at token 2, done 5 cycles after start.
    req_valid = 4'b0100;
    run_block(2, 5, 2, 1'b0, 1'b1, 0);

    // Round-robin with every requester pending.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int b = 0; b < 8; b++) run_block(b % 4, 1 + (b % 3), b % 4, 1'b0, 1'b0, b + 1);
    req_valid = '0;
    tick();

    // Backpressure, full 32-token result with no NUL code.
    req_valid = 4'b0001;
    run_block(0, 3, -1, 1'b1, 1'b1, 5);

    // Timeout on requester 1; rr has advanced to 2.
    req_valid = 4'b0010;
    #1;
    check_eq("tmo_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    t0 = n_tmo;
    o0 = n_ov;
    for (int c = 1; c <= int'(MAXCYC); c++) tick();
    check_eq("tmo_still_wait", busy, 1);
    check_eq("tmo_none_early", n_tmo - t0, 0);
    tick();
    check_eq("tmo_pulse", err_timeout, 1);
    check_eq("tmo_idle", busy, 0);
    tick();
    eng_done = 1'b1;
    eng_y    = '1;
    tick();
    eng_done = 1'b0;
    check_eq("spurious_valid", out_valid, 0);
    check_eq("spurious_busy", busy, 0);
    check_eq("tmo_one_pulse", n_tmo - t0, 1);
    check_eq("tmo_no_tokens", n_ov - o0, 0);
    req_valid = 4'b1111;
    run_block(2, 4, 1, 1'b0, 1'b1, 7);

    // Reset asserted while presenting token 4.
    fill_tokens(-1, 11);
    req_valid = 4'b1000;
    #1;
    check_eq("mid_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("mid_tok", out_data, tok_mem[k]);
      tick();
    end
    check_eq("mid_tok4", out_data, tok_mem[4]);
    reset = 1'b1;
    tick();
    check_reset_vals("mid_rst");
    reset = 1'b0;
    req_valid = 4'b1010;
    run_block(1, 2, 5, 1'b0, 1'b1, 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
